// File: rtl/jesd204_tx_link_seq.sv
// JESD204B transmit link-layer sequencer: CGS / ILAS / DATA generation, 4 octets
// per lane per clock, with a SYSREF-aligned LMFC counter and SYNC_n resync handling.
module jesd204_tx_link_seq #(
  parameter int LANES        = 4,
  parameter int SYNC_REQ_CYC = 4
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic                         EN,
  input  logic [7:0]                   F,
  input  logic [4:0]                   K,
  input  logic [7:0]                   NUM_ILAS,
  input  logic [LANES-1:0]             LANE_EN,
  input  logic [LANES-1:0][13:0][7:0]  CFG,
  input  logic                         SYNC_n,
  input  logic                         SYSREF,
  input  logic [LANES-1:0][3:0][7:0]   DI,
  output logic [LANES-1:0][3:0][7:0]   DO,
  output logic [LANES-1:0][3:0]        DO_K,
  output logic                         RDY,
  output logic [1:0]                   STATE,
  output logic                         LMFC
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CGS  = 2'd1,
    ST_ILAS = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam int               RUN_W    = $clog2(SYNC_REQ_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(SYNC_REQ_CYC - 1);

  localparam logic [7:0] OCT_K28_5 = 8'hBC;
  localparam logic [7:0] OCT_R     = 8'h1C;
  localparam logic [7:0] OCT_A     = 8'h7C;
  localparam logic [7:0] OCT_Q     = 8'h9C;

  // Multiframe geometry; the configuration is static while the link runs.
  logic [13:0] f_plus1;
  logic [13:0] k_plus1;
  logic [13:0] mf_oct;
  logic [13:0] mf_oct_m1;
  logic [11:0] mf_cyc_m1;

  assign f_plus1   = {6'd0, F} + 14'd1;
  assign k_plus1   = {9'd0, K} + 14'd1;
  assign mf_oct    = f_plus1 * k_plus1;
  assign mf_oct_m1 = mf_oct - 14'd1;
  assign mf_cyc_m1 = mf_oct[13:2] - 12'd1;

  state_t           state_reg, state_next;
  logic [10:0]      lmfc_cnt_reg, lmfc_cnt_next;
  logic             sysref_d_reg;
  logic             sysref_edge;
  logic [10:0]      ilas_cyc_reg, ilas_cyc_next;
  logic [7:0]       ilas_mf_reg, ilas_mf_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic             ilas_cyc_last;

  logic [LANES-1:0][3:0][7:0] do_reg, do_next;
  logic [LANES-1:0][3:0]      do_k_reg, do_k_next;
  logic                       rdy_reg;
  logic [1:0]                 state_out_reg;
  logic                       lmfc_reg;

  assign sysref_edge   = SYSREF & ~sysref_d_reg;
  assign ilas_cyc_last = ({1'b0, ilas_cyc_reg} >= mf_cyc_m1);

  always_comb begin
    lmfc_cnt_next = lmfc_cnt_reg + 11'd1;
    if (sysref_edge || ({1'b0, lmfc_cnt_reg} >= mf_cyc_m1)) begin
      lmfc_cnt_next = 11'd0;
    end
  end

  // lmfc_cnt_next == 0 means the cycle after this edge is a multiframe
  // boundary, so ILAS octet 0 lines up with the LMFC pulse on the outputs.
  always_comb begin
    state_next    = state_reg;
    ilas_cyc_next = ilas_cyc_reg;
    ilas_mf_next  = ilas_mf_reg;
    run_next      = '0;
    if (!EN) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_CGS;
        ST_CGS: begin
          if ((lmfc_cnt_next == 11'd0) && SYNC_n) begin
            state_next    = ST_ILAS;
            ilas_cyc_next = 11'd0;
            ilas_mf_next  = 8'd0;
          end
        end
        ST_ILAS: begin
          if (!SYNC_n) begin
            state_next = ST_CGS;
          end else if (ilas_cyc_last) begin
            ilas_cyc_next = 11'd0;
            ilas_mf_next  = ilas_mf_reg + 8'd1;
            if (ilas_mf_reg == NUM_ILAS) begin
              state_next = ST_DATA;
            end
          end else begin
            ilas_cyc_next = ilas_cyc_reg + 11'd1;
          end
        end
        ST_DATA: begin
          if (!SYNC_n) begin
            if (run_reg == RUN_LAST) begin
              state_next = ST_CGS;
            end else begin
              run_next = run_reg + 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    for (genvar gj = 0; gj < 4; gj++) begin : g_oct
      logic [12:0] pos;
      logic [3:0]  cfg_idx;
      logic [7:0]  oct;
      logic        is_k;

      assign pos     = {ilas_cyc_reg, 2'(gj)};
      assign cfg_idx = pos[3:0] - 4'd2;

      always_comb begin
        oct  = 8'h00;
        is_k = 1'b0;
        if (LANE_EN[gi]) begin
          case (state_reg)
            ST_CGS: begin
              oct  = OCT_K28_5;
              is_k = 1'b1;
            end
            ST_ILAS: begin
              if (pos == 13'd0) begin
                oct  = OCT_R;
                is_k = 1'b1;
              end else if ({1'b0, pos} == mf_oct_m1) begin
                oct  = OCT_A;
                is_k = 1'b1;
              end else if ((ilas_mf_reg == 8'd1) && (pos == 13'd1)) begin
                oct  = OCT_Q;
                is_k = 1'b1;
              end else if ((ilas_mf_reg == 8'd1) && (pos >= 13'd2) && (pos <= 13'd15)) begin
                oct = CFG[gi][cfg_idx];
              end else begin
                oct = pos[7:0];
              end
            end
            ST_DATA: oct = DI[gi][gj];
            default: oct = 8'h00;
          endcase
        end
      end

      assign do_next[gi][gj]   = oct;
      assign do_k_next[gi][gj] = is_k;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg     <= ST_IDLE;
      lmfc_cnt_reg  <= 11'd0;
      sysref_d_reg  <= 1'b0;
      ilas_cyc_reg  <= 11'd0;
      ilas_mf_reg   <= 8'd0;
      run_reg       <= '0;
      do_reg        <= '0;
      do_k_reg      <= '0;
      rdy_reg       <= 1'b0;
      state_out_reg <= 2'd0;
      lmfc_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lmfc_cnt_reg  <= lmfc_cnt_next;
      sysref_d_reg  <= SYSREF;
      ilas_cyc_reg  <= ilas_cyc_next;
      ilas_mf_reg   <= ilas_mf_next;
      run_reg       <= run_next;
      do_reg        <= do_next;
      do_k_reg      <= do_k_next;
      rdy_reg       <= (state_reg == ST_DATA);
      state_out_reg <= state_reg;
      lmfc_reg      <= (lmfc_cnt_reg == 11'd0);
    end
  end

  assign DO    = do_reg;
  assign DO_K  = do_k_reg;
  assign RDY   = rdy_reg;
  assign STATE = state_out_reg;
  assign LMFC  = lmfc_reg;

endmodule
